// File: rtl/robo_pkg.sv
// Shared types and helpers for the wall-following controller.
package robo_pkg;

  // Heading encodings
  localparam logic [1:0] HDG_N = 2'b00;
  localparam logic [1:0] HDG_S = 2'b01;
  localparam logic [1:0] HDG_L = 2'b10;
  localparam logic [1:0] HDG_O = 2'b11;

  typedef enum logic [2:0] {
    ST_SEEK      = 3'd0,
    ST_FOLLOW    = 3'd1,
    ST_POST_TURN = 3'd2,
    ST_DONE      = 3'd3,
    ST_TRAPPED   = 3'd4
  } state_e;

  // Counter width able to hold 0..max_v, never narrower than one bit
  function automatic int unsigned cnt_w(input int unsigned max_v);
    return (max_v == 0) ? 1 : $clog2(max_v + 1);
  endfunction

  // Counter-clockwise quarter turn: N->O->S->L->N
  function automatic logic [1:0] rot_ccw(input logic [1:0] h);
    case (h)
      HDG_N:   return HDG_O;
      HDG_O:   return HDG_S;
      HDG_S:   return HDG_L;
      default: return HDG_N;
    endcase
  endfunction

  // Clockwise quarter turn: N->L->S->O->N
  function automatic logic [1:0] rot_cw(input logic [1:0] h);
    case (h)
      HDG_N:   return HDG_L;
      HDG_L:   return HDG_S;
      HDG_S:   return HDG_O;
      default: return HDG_N;
    endcase
  endfunction

endpackage

// File: rtl/robo_follower_if.sv
// Sensor-in / command-out bundle between front-end and controller.
interface robo_follower_if #(
  parameter int unsigned MW = 8
);
  logic          sense_valid;
  logic          head;
  logic          side;
  logic          avancar;
  logic          girar;
  logic          girar_dir;
  logic [1:0]    orient;
  logic [MW-1:0] moves;
  logic          done;
  logic          trapped;

  modport master (
    output sense_valid, head, side,
    input  avancar, girar, girar_dir, orient, moves, done, trapped
  );

  modport slave (
    input  sense_valid, head, side,
    output avancar, girar, girar_dir, orient, moves, done, trapped
  );
endinterface

// File: rtl/robo_heading.sv
// Heading register, rotated a quarter turn on each turn strobe.
module robo_heading
  import robo_pkg::*;
#(
  parameter logic [1:0] INIT_ORIENT = HDG_N
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       turn,
  input  logic       dir,
  output logic [1:0] orient
);

  logic [1:0] orient_d, orient_q;

  // Next heading: cw when dir=1, ccw when dir=0
  always_comb begin
    orient_d = orient_q;
    if (turn) begin
      orient_d = dir ? rot_cw(orient_q) : rot_ccw(orient_q);
    end
  end

  // Heading register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) orient_q <= INIT_ORIENT;
    else       orient_q <= orient_d;
  end

  assign orient = orient_q;

endmodule

// File: rtl/robo_follower.sv
// Wall-following controller: one registered command per sensor sample.
module robo_follower
  import robo_pkg::*;
#(
  parameter int unsigned HAND        = 0,
  parameter int unsigned MAX_MOVES   = 255,
  parameter int unsigned TURN_LIMIT  = 4,
  parameter logic [1:0]  INIT_ORIENT = 2'b00
) (
  input  logic            clock,
  input  logic            reset,
  robo_follower_if.slave  bus
);

  localparam int unsigned MW = cnt_w(MAX_MOVES);
  localparam int unsigned SW = cnt_w(TURN_LIMIT);
  localparam logic        TOWARD = 1'(HAND);
  localparam logic        AWAY   = ~TOWARD;
  localparam state_e      RST_STATE = (MAX_MOVES == 0) ? ST_DONE : ST_SEEK;
  localparam logic        RST_DONE  = (MAX_MOVES == 0);

  state_e        state_d, state_q;
  logic          avancar_d, avancar_q;
  logic          girar_d, girar_q;
  logic          girar_dir_d, girar_dir_q;
  logic [MW-1:0] moves_d, moves_q;
  logic [SW-1:0] streak_d, streak_q;
  logic          done_d, done_q;
  logic          trapped_d, trapped_q;
  logic          active_c;
  logic          budget_c;
  logic          trap_c;

  // FSM state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= RST_STATE;
    else       state_q <= state_d;
  end

  // Next state from the command chosen this sample; budget wins over trap
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_SEEK:      if (girar_d) state_d = ST_FOLLOW;
      ST_FOLLOW:    if (girar_d && (girar_dir_d == TOWARD)) state_d = ST_POST_TURN;
      ST_POST_TURN: if (girar_d || avancar_d) state_d = ST_FOLLOW;
      default:      state_d = state_q;
    endcase
    if (budget_c)    state_d = ST_DONE;
    else if (trap_c) state_d = ST_TRAPPED;
    done_d    = (state_d == ST_DONE);
    trapped_d = (state_d == ST_TRAPPED);
  end

  // Command decode plus move/streak counter updates
  always_comb begin
    avancar_d   = 1'b0;
    girar_d     = 1'b0;
    girar_dir_d = 1'b0;
    active_c    = bus.sense_valid &&
                  ((state_q == ST_SEEK) || (state_q == ST_FOLLOW) || (state_q == ST_POST_TURN));
    if (active_c) begin
      case (state_q)
        ST_FOLLOW: begin
          if (!bus.side) begin
            girar_d     = 1'b1;
            girar_dir_d = TOWARD;
          end else if (!bus.head) begin
            avancar_d = 1'b1;
          end else begin
            girar_d     = 1'b1;
            girar_dir_d = AWAY;
          end
        end
        default: begin
          if (!bus.head) begin
            avancar_d = 1'b1;
          end else begin
            girar_d     = 1'b1;
            girar_dir_d = AWAY;
          end
        end
      endcase
    end

    moves_d  = moves_q;
    streak_d = streak_q;
    if (avancar_d) begin
      if (moves_q != MW'(MAX_MOVES)) moves_d = moves_q + MW'(1);
      streak_d = '0;
    end else if (girar_d) begin
      if (streak_q != SW'(TURN_LIMIT)) streak_d = streak_q + SW'(1);
    end

    budget_c = avancar_d && ((moves_q + MW'(1)) == MW'(MAX_MOVES));
    trap_c   = girar_d && ((streak_q + SW'(1)) == SW'(TURN_LIMIT));
  end

  // Registered outputs and counters
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      avancar_q   <= 1'b0;
      girar_q     <= 1'b0;
      girar_dir_q <= 1'b0;
      moves_q     <= '0;
      streak_q    <= '0;
      done_q      <= RST_DONE;
      trapped_q   <= 1'b0;
    end else begin
      avancar_q   <= avancar_d;
      girar_q     <= girar_d;
      girar_dir_q <= girar_dir_d;
      moves_q     <= moves_d;
      streak_q    <= streak_d;
      done_q      <= done_d;
      trapped_q   <= trapped_d;
    end
  end

  robo_heading #(
    .INIT_ORIENT (INIT_ORIENT)
  ) u_heading (
    .clock  (clock),
    .reset  (reset),
    .turn   (girar_d),
    .dir    (girar_dir_d),
    .orient (bus.orient)
  );

  assign bus.avancar   = avancar_q;
  assign bus.girar     = girar_q;
  assign bus.girar_dir = girar_dir_q;
  assign bus.moves     = moves_q;
  assign bus.done      = done_q;
  assign bus.trapped   = trapped_q;

endmodule

// File: tb/tb_robo_follower.sv
// Directed bench: four controller configurations on a shared clock and reset.
module tb_robo_follower;
  import robo_pkg::*;

  localparam int N = 0;
  localparam int S = 1;
  localparam int L = 2;
  localparam int O = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;
  logic [14:0] exp_v;

  logic       sv [4];
  logic       hd [4];
  logic       sd [4];
  logic       adv [4];
  logic       gir [4];
  logic       gdir [4];
  logic [1:0] ori [4];
  logic [7:0] mv [4];
  logic       dn [4];
  logic       tr [4];

  always #5 clock = ~clock;

  // u0: left hand, north;  u1: right hand, west;  u2: budget 3;  u3: budget 0
  robo_follower_if #(.MW(cnt_w(255))) if0 ();
  robo_follower_if #(.MW(cnt_w(255))) if1 ();
  robo_follower_if #(.MW(cnt_w(3)))   if2 ();
  robo_follower_if #(.MW(cnt_w(0)))   if3 ();

  robo_follower #(.HAND(0), .MAX_MOVES(255), .TURN_LIMIT(4), .INIT_ORIENT(2'b00))
    u0 (.clock(clock), .reset(reset), .bus(if0));
  robo_follower #(.HAND(1), .MAX_MOVES(255), .TURN_LIMIT(4), .INIT_ORIENT(2'b11))
    u1 (.clock(clock), .reset(reset), .bus(if1));
  robo_follower #(.HAND(0), .MAX_MOVES(3), .TURN_LIMIT(4), .INIT_ORIENT(2'b00))
    u2 (.clock(clock), .reset(reset), .bus(if2));
  robo_follower #(.HAND(0), .MAX_MOVES(0), .TURN_LIMIT(4), .INIT_ORIENT(2'b00))
    u3 (.clock(clock), .reset(reset), .bus(if3));

  assign if0.sense_valid = sv[0]; assign if0.head = hd[0]; assign if0.side = sd[0];
  assign if1.sense_valid = sv[1]; assign if1.head = hd[1]; assign if1.side = sd[1];
  assign if2.sense_valid = sv[2]; assign if2.head = hd[2]; assign if2.side = sd[2];
  assign if3.sense_valid = sv[3]; assign if3.head = hd[3]; assign if3.side = sd[3];

  assign adv[0] = if0.avancar; assign gir[0] = if0.girar; assign gdir[0] = if0.girar_dir;
  assign ori[0] = if0.orient;  assign mv[0] = 8'(if0.moves); assign dn[0] = if0.done; assign tr[0] = if0.trapped;
  assign adv[1] = if1.avancar; assign gir[1] = if1.girar; assign gdir[1] = if1.girar_dir;
  assign ori[1] = if1.orient;  assign mv[1] = 8'(if1.moves); assign dn[1] = if1.done; assign tr[1] = if1.trapped;
  assign adv[2] = if2.avancar; assign gir[2] = if2.girar; assign gdir[2] = if2.girar_dir;
  assign ori[2] = if2.orient;  assign mv[2] = 8'(if2.moves); assign dn[2] = if2.done; assign tr[2] = if2.trapped;
  assign adv[3] = if3.avancar; assign gir[3] = if3.girar; assign gdir[3] = if3.girar_dir;
  assign ori[3] = if3.orient;  assign mv[3] = 8'(if3.moves); assign dn[3] = if3.done; assign tr[3] = if3.trapped;

  // Packed observation: {avancar, girar, girar_dir, orient, moves, done, trapped}
  function automatic logic [14:0] snap(input int d);
    return {adv[d], gir[d], gdir[d], ori[d], mv[d], dn[d], tr[d]};
  endfunction

  function automatic logic [14:0] e(input int a, input int g, input int dr, input int o,
                                    input int m, input int dne, input int tre);
    return {1'(a), 1'(g), 1'(dr), 2'(o), 8'(m), 1'(dne), 1'(tre)};
  endfunction

  // One sample to DUT d at the next rising edge; returns 1 time unit after it
  task automatic drive(input int d, input logic h, input logic s);
    @(negedge clock);
    sv[d] = 1'b1; hd[d] = h; sd[d] = s;
    @(posedge clock);
    #1;
    sv[d] = 1'b0;
  endtask

  task automatic idle();
    @(negedge clock);
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    #12;
    exp_v = e(0,0,0,N,0,0,0); checks++;
    if (snap(0) !== exp_v) begin failures++; $display("FAIL reset_u0 got=%h exp=%h", snap(0), exp_v); end
    exp_v = e(0,0,0,O,0,0,0); checks++;
    if (snap(1) !== exp_v) begin failures++; $display("FAIL reset_u1 got=%h exp=%h", snap(1), exp_v); end
    exp_v = e(0,0,0,N,0,0,0); checks++;
    if (snap(2) !== exp_v) begin failures++; $display("FAIL reset_u2 got=%h exp=%h", snap(2), exp_v); end
    exp_v = e(0,0,0,N,0,1,0); checks++;
    if (snap(3) !== exp_v) begin failures++; $display("FAIL reset_u3_done got=%h exp=%h", snap(3), exp_v); end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_seek();
    drive(0, 1'b0, 1'b0);
    exp_v = e(1,0,0,N,1,0,0); checks++;
    if (snap(0) !== exp_v) begin failures++; $display("FAIL seek_adv1 got=%h exp=%h", snap(0), exp_v); end
    drive(0, 1'b0, 1'b1);
    exp_v = e(1,0,0,N,2,0,0); checks++;
    if (snap(0) !== exp_v) begin failures++; $display("FAIL seek_adv2 got=%h exp=%h", snap(0), exp_v); end
    drive(0, 1'b1, 1'b0);
    exp_v = e(0,1,1,L,2,0,0); checks++;
    if (snap(0) !== exp_v) begin failures++; $display("FAIL seek_away got=%h exp=%h", snap(0), exp_v); end
    idle();
    exp_v = e(0,0,0,L,2,0,0); checks++;
    if (snap(0) !== exp_v) begin failures++; $display("FAIL seek_idle_hold got=%h exp=%h", snap(0), exp_v); end
  endtask

  task automatic test_corner();
    drive(0, 1'b0, 1'b0);
    exp_v = e(0,1,0,N,2,0,0); checks++;
    if (snap(0) !== exp_v) begin failures++; $display("FAIL corner_toward1 got=%h exp=%h", snap(0), exp_v); end
    drive(0, 1'b0, 1'b1);
    exp_v = e(1,0,0,N,3,0,0); checks++;
    if (snap(0) !== exp_v) begin failures++; $display("FAIL corner_post_adv1 got=%h exp=%h", snap(0), exp_v); end
    drive(0, 1'b0, 1'b0);
    exp_v = e(0,1,0,O,3,0,0); checks++;
    if (snap(0) !== exp_v) begin failures++; $display("FAIL corner_toward2 got=%h exp=%h", snap(0), exp_v); end
    drive(0, 1'b0, 1'b1);
    exp_v = e(1,0,0,O,4,0,0); checks++;
    if (snap(0) !== exp_v) begin failures++; $display("FAIL corner_post_adv2 got=%h exp=%h", snap(0), exp_v); end
  endtask

  task automatic test_trap();
    int exp_or [4] = '{N, L, S, O};
    for (int i = 0; i < 4; i++) begin
      drive(0, 1'b1, 1'b1);
      exp_v = e(0,1,1,exp_or[i],4,0,(i == 3) ? 1 : 0); checks++;
      if (snap(0) !== exp_v) begin failures++; $display("FAIL trap_turn%0d got=%h exp=%h", i, snap(0), exp_v); end
    end
    drive(0, 1'b0, 1'b1);
    exp_v = e(0,0,0,O,4,0,1); checks++;
    if (snap(0) !== exp_v) begin failures++; $display("FAIL trap_ignore_adv got=%h exp=%h", snap(0), exp_v); end
    drive(0, 1'b1, 1'b0);
    exp_v = e(0,0,0,O,4,0,1); checks++;
    if (snap(0) !== exp_v) begin failures++; $display("FAIL trap_ignore_turn got=%h exp=%h", snap(0), exp_v); end
  endtask

  task automatic test_dead_end();
    int exp_or [3] = '{O, S, L};
    drive(1, 1'b1, 1'b0);
    exp_v = e(0,1,0,S,0,0,0); checks++;
    if (snap(1) !== exp_v) begin failures++; $display("FAIL dead_seek_away got=%h exp=%h", snap(1), exp_v); end
    drive(1, 1'b1, 1'b1);
    exp_v = e(0,1,0,L,0,0,0); checks++;
    if (snap(1) !== exp_v) begin failures++; $display("FAIL dead_ccw1 got=%h exp=%h", snap(1), exp_v); end
    drive(1, 1'b1, 1'b1);
    exp_v = e(0,1,0,N,0,0,0); checks++;
    if (snap(1) !== exp_v) begin failures++; $display("FAIL dead_ccw2 got=%h exp=%h", snap(1), exp_v); end
    drive(1, 1'b0, 1'b1);
    exp_v = e(1,0,0,N,1,0,0); checks++;
    if (snap(1) !== exp_v) begin failures++; $display("FAIL dead_adv got=%h exp=%h", snap(1), exp_v); end
    // Three more turns stay below the limit only if the streak was cleared
    for (int i = 0; i < 3; i++) begin
      drive(1, 1'b1, 1'b1);
      exp_v = e(0,1,0,exp_or[i],1,0,0); checks++;
      if (snap(1) !== exp_v) begin failures++; $display("FAIL dead_streak_clear%0d got=%h exp=%h", i, snap(1), exp_v); end
    end
  endtask

  task automatic test_budget();
    for (int i = 1; i <= 5; i++) begin
      drive(2, 1'b0, 1'b1);
      if (i <= 3) exp_v = e(1,0,0,N,i,(i == 3) ? 1 : 0,0);
      else        exp_v = e(0,0,0,N,3,1,0);
      checks++;
      if (snap(2) !== exp_v) begin failures++; $display("FAIL budget_s%0d got=%h exp=%h", i, snap(2), exp_v); end
    end
  endtask

  task automatic test_zero_budget();
    drive(3, 1'b0, 1'b0);
    exp_v = e(0,0,0,N,0,1,0); checks++;
    if (snap(3) !== exp_v) begin failures++; $display("FAIL zero_budget_adv got=%h exp=%h", snap(3), exp_v); end
    drive(3, 1'b1, 1'b1);
    exp_v = e(0,0,0,N,0,1,0); checks++;
    if (snap(3) !== exp_v) begin failures++; $display("FAIL zero_budget_turn got=%h exp=%h", snap(3), exp_v); end
  endtask

  task automatic test_async_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    drive(0, 1'b1, 1'b0);
    exp_v = e(0,1,1,L,0,0,0); checks++;
    if (snap(0) !== exp_v) begin failures++; $display("FAIL async_pre_pulse got=%h exp=%h", snap(0), exp_v); end
    #2;
    reset = 1'b1;
    #1;
    exp_v = e(0,0,0,N,0,0,0); checks++;
    if (snap(0) !== exp_v) begin failures++; $display("FAIL async_u0_cleared got=%h exp=%h", snap(0), exp_v); end
    exp_v = e(0,0,0,N,0,0,0); checks++;
    if (snap(2) !== exp_v) begin failures++; $display("FAIL async_u2_done_cleared got=%h exp=%h", snap(2), exp_v); end
    exp_v = e(0,0,0,N,0,1,0); checks++;
    if (snap(3) !== exp_v) begin failures++; $display("FAIL async_u3_done_kept got=%h exp=%h", snap(3), exp_v); end
    @(negedge clock);
    reset = 1'b0;
    drive(0, 1'b0, 1'b0);
    exp_v = e(1,0,0,N,1,0,0); checks++;
    if (snap(0) !== exp_v) begin failures++; $display("FAIL async_first_sample got=%h exp=%h", snap(0), exp_v); end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      sv[i] = 1'b0; hd[i] = 1'b0; sd[i] = 1'b0;
    end
    test_reset();
    test_seek();
    test_corner();
    test_trap();
    test_dead_end();
    test_budget();
    test_zero_budget();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/robo_follower.md
# robo_follower

Parametrised wall-following controller, next generation of the `Robo` block. It consumes one sensor sample per `sense_valid` strobe and issues exactly one registered command per sample: advance, or turn 90° in an explicit direction. It supports left- or right-hand following and tracks heading and move count internally. It stops cleanly on a move budget or on a detected trap. It sits between the sensor front-end (or the map-driven bench) and the motion actuator.

## Interface
- `HAND`, 0: wall followed on 0 = left side, 1 = right side.
- `MAX_MOVES`, 255: advance budget; `done` asserts on reaching it.
- `TURN_LIMIT`, 4: consecutive turns without an advance that declare a trap.
- `INIT_ORIENT`, 2'b00: heading after reset (N=00, S=01, L=10, O=11).
- `clock`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-high.
- `sense_valid`  in  1: `head`/`side` valid this cycle.
- `head`  in  1: wall directly ahead.
- `side`  in  1: wall on the followed side.
- `avancar`  out  1: one-cycle pulse, move one cell forward.
- `girar`  out  1: one-cycle pulse, rotate 90°.
- `girar_dir`  out  1: valid with `girar`; 0 = CCW (left), 1 = CW (right).
- `orient`  out  2: current heading.
- `moves`  out  MW: advances issued, MW = $clog2(MAX_MOVES+1).
- `done`  out  1: sticky, budget reached.
- `trapped`  out  1: sticky, trap detected.

## Operation
- States: SEEK, FOLLOW, POST_TURN, DONE, TRAPPED. Reset state is SEEK.
- Define TOWARD = turn toward the followed side (`girar_dir` = HAND). Define AWAY = turn away from it (`girar_dir` = !HAND).
- SEEK: `head`=0 → advance. `head`=1 → AWAY, then go to FOLLOW. `side` is ignored.
- FOLLOW:
  - `side`=0 → TOWARD, then go to POST_TURN.
  - else `head`=0 → advance.
  - else → AWAY.
- POST_TURN: `side` is ignored. `head`=0 → advance, then go to FOLLOW. `head`=1 → AWAY, then go to FOLLOW.
- Heading update is mod 4 on every turn:
  - CCW: N→O→S→L→N.
  - CW: N→L→S→O→N.
- Advance handling:
  - `moves` increments on each advance.
  - The turn-streak counter clears on each advance.
  - When `moves` reaches MAX_MOVES → DONE.
- Turn handling: each turn increments the streak. When the streak reaches TURN_LIMIT after that turn → TRAPPED. The limiting turn itself is still issued.
- DONE/TRAPPED: `sense_valid` is ignored and no commands are issued. Only `reset` exits either state.
- If the budget and trap conditions could both apply on one sample, DONE takes priority. This cannot actually occur, because they are triggered by different commands.
- MAX_MOVES=0: `done` asserts out of reset and no command is ever issued.

## Timing
- Values during reset: `avancar`=`girar`=`girar_dir`=0, `orient`=INIT_ORIENT, `moves`=0, `done`=`trapped`=0. The streak counter is 0 and the state is SEEK, except MAX_MOVES=0, which resets straight into DONE.
- Latency: `sense_valid` sampled high at edge k → command pulse high from edge k to edge k+1. `orient`, `moves`, `done` and `trapped` update at edge k as well.
- Back-to-back `sense_valid` is legal, giving one command per cycle. With no `sense_valid`, both command outputs are 0 and all other outputs hold.
- `avancar` and `girar` are never high in the same cycle.
- Reset is asynchronous: asserting it mid-pulse clears the outputs immediately. Deassertion is synchronised externally, and the first sample is taken at the first edge after release.

## Structure
- `robo_pkg` holds:
  - heading encodings N/S/L/O;
  - the state enum;
  - `rot_ccw`/`rot_cw` functions (2-bit → 2-bit).
- Sub-module `robo_heading` contains the heading register and rotate logic. Inputs: `clock`, `reset`, turn strobe, direction. Output: `orient`.
- The top level holds the FSM, move counter (saturating at MAX_MOVES) and streak counter (width $clog2(TURN_LIMIT+1)).

## Test plan
- Reset/seek, HAND=0, INIT_ORIENT=N: samples (`head`,`side`) = (0,x),(0,x),(1,x) → avancar, avancar, girar with `girar_dir`=1. End state: `orient`=L, `moves`=2, state FOLLOW.
- Left-hand corner: in FOLLOW facing N, samples (0,0) then (0,1) → CCW turn (`orient`=O), then avancar. The streak clears and `moves` increments.
- Dead end, HAND=1, facing S: samples (1,1),(1,1),(0,1) → CCW, CCW, avancar. Final `orient`=N and the streak returns to 0.
- Trap, TURN_LIMIT=4: four consecutive samples (1,1) in FOLLOW → four AWAY pulses, and `trapped`=1 one edge after the fourth sample. A further `sense_valid` produces no pulse and `orient` stays unchanged.
- Budget, MAX_MOVES=3: open corridor with `sense_valid` on every cycle → exactly 3 avancar pulses, `moves`=3 and `done`=1 after the third. Later samples are ignored.
- Async reset mid-run: assert `reset` between clock edges while `girar`=1 → all outputs return to their reset values before the next edge.
